// File: rtl/aes_byte_frontend_if.sv
// Byte-stream and core-side bundle for aes_byte_frontend.
// master = host/core side, slave = the frontend itself.
interface aes_byte_frontend_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         key_reuse;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] aes_key;
    logic [127:0] aes_plaintext;
    logic         aes_trigger;
    logic [127:0] aes_ciphertext;
    logic         aes_done;
    logic         busy;
    logic         error;

    modport master (
        output in_data, in_valid, key_reuse, out_ready, aes_ciphertext, aes_done,
        input  in_ready, out_data, out_valid, aes_key, aes_plaintext, aes_trigger, busy, error
    );

    modport slave (
        input  in_data, in_valid, key_reuse, out_ready, aes_ciphertext, aes_done,
        output in_ready, out_data, out_valid, aes_key, aes_plaintext, aes_trigger, busy, error
    );
endinterface

// File: rtl/aes_byte_frontend.sv
// Byte-wide front end for the AES-128 core: loads key/plaintext MSB-first,
// triggers the core, tracks its done level and streams the ciphertext back out.
module aes_byte_frontend #(
    parameter int WAIT_LIMIT = 1023
) (
    input  logic                clk,
    input  logic                reset_n,
    aes_byte_frontend_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, LOAD_KEY, LOAD_PT, START, WAIT_LOW, WAIT_HIGH, SEND
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

    state_t         state_r, state_s;
    logic [4:0]     cnt_r;
    logic [15:0]    wait_cnt_r;
    logic [127:0]   key_r, pt_r, shift_r;
    logic           key_loaded_r, error_r;
    logic           in_ready_r, out_valid_r, trig_r, busy_r;
    logic           in_acc_s, out_acc_s, timeout_s, to_pt_s;

    assign bus.in_ready      = in_ready_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_data      = shift_r[127:120];
    assign bus.aes_key       = key_r;
    assign bus.aes_plaintext = pt_r;
    assign bus.aes_trigger   = trig_r;
    assign bus.busy          = busy_r;
    assign bus.error         = error_r;

    // Next-state selection and transfer strobes.
    always_comb begin
        state_s   = state_r;
        in_acc_s  = bus.in_valid & in_ready_r;
        out_acc_s = out_valid_r & bus.out_ready;
        to_pt_s   = bus.key_reuse & key_loaded_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_acc_s) begin
                    state_s = to_pt_s ? LOAD_PT : LOAD_KEY;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_KEY: begin
                if (in_acc_s && cnt_r == 5'd15) begin
                    state_s = LOAD_PT;
                end else begin
                    state_s = LOAD_KEY;
                end
            end
            LOAD_PT: begin
                if (in_acc_s && cnt_r == 5'd15) begin
                    state_s = START;
                end else begin
                    state_s = LOAD_PT;
                end
            end
            START: state_s = WAIT_LOW;
            // A core response on the last allowed cycle still wins over the timeout.
            WAIT_LOW: begin
                if (!bus.aes_done) begin
                    state_s = WAIT_HIGH;
                end else if (wait_cnt_r >= WAIT_LAST) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = WAIT_LOW;
                end
            end
            WAIT_HIGH: begin
                if (bus.aes_done) begin
                    state_s = SEND;
                end else if (wait_cnt_r >= WAIT_LAST) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = WAIT_HIGH;
                end
            end
            SEND: begin
                if (out_acc_s && cnt_r == 5'd15) begin
                    state_s = IDLE;
                end else begin
                    state_s = SEND;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            trig_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE) || (state_s == LOAD_KEY) || (state_s == LOAD_PT);
            out_valid_r <= (state_s == SEND);
            trig_r      <= (state_s == START);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Datapath: load shift registers, counters, key_loaded and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= 5'd0;
            wait_cnt_r   <= 16'd0;
            key_r        <= 128'd0;
            pt_r         <= 128'd0;
            shift_r      <= 128'd0;
            key_loaded_r <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_acc_s) begin
                        error_r <= 1'b0;
                        cnt_r   <= 5'd1;
                        if (to_pt_s) begin
                            pt_r <= {pt_r[119:0], bus.in_data};
                        end else begin
                            key_r <= {key_r[119:0], bus.in_data};
                        end
                    end
                end
                LOAD_KEY: begin
                    if (in_acc_s) begin
                        key_r <= {key_r[119:0], bus.in_data};
                        if (cnt_r == 5'd15) begin
                            cnt_r        <= 5'd0;
                            key_loaded_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end
                end
                LOAD_PT: begin
                    if (in_acc_s) begin
                        pt_r  <= {pt_r[119:0], bus.in_data};
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                START: begin
                    wait_cnt_r <= 16'd0;
                    cnt_r      <= 5'd0;
                end
                WAIT_LOW, WAIT_HIGH: begin
                    if (wait_cnt_r != 16'hFFFF) begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
                    end
                    if (timeout_s) begin
                        error_r <= 1'b1;
                    end
                    if (state_r == WAIT_HIGH && bus.aes_done) begin
                        shift_r <= bus.aes_ciphertext;
                    end
                end
                SEND: begin
                    if (out_acc_s) begin
                        shift_r <= {shift_r[119:0], 8'h00};
                        cnt_r   <= cnt_r + 5'd1;
                    end
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_byte_frontend.sv
// Directed bench for aes_byte_frontend with a small behavioural AES core stand-in.
module tb_aes_byte_frontend;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   trig_cnt = 0;
    int   trig_neg = 0;
    int   neg_cnt = 0;
    bit   core_stuck = 1'b0;
    logic [2:0] core_cnt;

    always #5 clk = ~clk;

    aes_byte_frontend_if bus();

    aes_byte_frontend #(.WAIT_LIMIT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Core stand-in: known FIPS vectors, otherwise a fixed mixing function.
    function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] p);
        if (k == C1_KEY && p == C1_PT) return C1_CT;
        if (k == B_KEY && p == B_PT) return B_CT;
        return k ^ {p[63:0], p[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.aes_done       <= 1'b1;
            bus.aes_ciphertext <= 128'd0;
            core_cnt           <= 3'd0;
        end else if (bus.aes_trigger && !core_stuck) begin
            bus.aes_done <= 1'b0;
            core_cnt     <= 3'd4;
        end else if (core_cnt != 3'd0) begin
            core_cnt <= core_cnt - 3'd1;
            if (core_cnt == 3'd1) begin
                bus.aes_done       <= 1'b1;
                bus.aes_ciphertext <= core_model(bus.aes_key, bus.aes_plaintext);
            end
        end
    end

    always @(negedge clk) begin
        if (bus.aes_trigger) begin
            trig_cnt = trig_cnt + 1;
            trig_neg = neg_cnt;
        end
        neg_cnt = neg_cnt + 1;
    end

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++; failures++;
            $display("FAIL send_byte timeout: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic send_frame(input logic reuse, input bit with_key,
                              input logic [127:0] key, input logic [127:0] pt);
        bus.key_reuse = reuse;
        if (with_key) for (int i = 0; i < 16; i++) send_byte(key[127-8*i -: 8]);
        for (int i = 0; i < 16; i++) send_byte(pt[127-8*i -: 8]);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv_frame(input bit stall, output logic [127:0] got);
        int n = 0;
        int cyc = 0;
        int k = 0;
        bit holding = 1'b0;
        logic [7:0] held = 8'h00;
        got = 128'd0;
        while (n < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = stall ? (k % 3 == 0) : 1'b1;
            if (bus.out_valid) begin
                if (holding) begin
                    checks++;
                    if (bus.out_data !== held) begin
                        failures++;
                        $display("FAIL hold: out_data=%h required %h", bus.out_data, held);
                    end
                end
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL in_ready_in_send: in_ready=%b required 0", bus.in_ready);
                end
                if (bus.out_ready) begin
                    got = {got[119:0], bus.out_data};
                    n++;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held = bus.out_data;
                end
                k++;
            end
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL recv_count: transfers=%0d required 16", n);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_end: out_valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.aes_trigger !== 1'b0 ||
            bus.busy !== 1'b0 || bus.error !== 1'b0) begin
            failures++;
            $display("FAIL %s_ctrl: rdy=%b ov=%b trg=%b busy=%b err=%b required 1 0 0 0 0",
                     tag, bus.in_ready, bus.out_valid, bus.aes_trigger, bus.busy, bus.error);
        end
        checks++;
        if (bus.aes_key !== 128'd0 || bus.aes_plaintext !== 128'd0 || bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL %s_data: key=%h pt=%h od=%h required zeros",
                     tag, bus.aes_key, bus.aes_plaintext, bus.out_data);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_reset_values("reset");
    endtask

    task automatic test_c1();
        logic [127:0] got;
        int t0 = trig_cnt;
        send_frame(1'b0, 1'b1, C1_KEY, C1_PT);
        recv_frame(1'b0, got);
        checks++;
        if (got !== C1_CT) begin
            failures++;
            $display("FAIL c1_ct: got %h required %h", got, C1_CT);
        end
        checks++;
        if (trig_cnt - t0 != 1) begin
            failures++;
            $display("FAIL c1_trigger: pulses=%0d required 1", trig_cnt - t0);
        end
        checks++;
        if (bus.error !== 1'b0 || bus.aes_key !== C1_KEY) begin
            failures++;
            $display("FAIL c1_state: error=%b key=%h required 0 %h", bus.error, bus.aes_key, C1_KEY);
        end
    endtask

    task automatic test_key_reuse();
        logic [127:0] got;
        send_frame(1'b1, 1'b0, 128'd0, B_PT);
        recv_frame(1'b0, got);
        checks++;
        if (bus.aes_key !== C1_KEY) begin
            failures++;
            $display("FAIL reuse_key: key=%h required %h", bus.aes_key, C1_KEY);
        end
        checks++;
        if (got !== core_model(C1_KEY, B_PT)) begin
            failures++;
            $display("FAIL reuse_ct: got %h required %h", got, core_model(C1_KEY, B_PT));
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] got;
        send_frame(1'b1, 1'b0, 128'd0, C1_PT);
        recv_frame(1'b1, got);
        checks++;
        if (got !== C1_CT) begin
            failures++;
            $display("FAIL backpressure_ct: got %h required %h", got, C1_CT);
        end
    endtask

    task automatic test_reuse_no_key();
        logic [127:0] got;
        do_reset();
        bus.key_reuse = 1'b1;
        send_frame(1'b1, 1'b1, B_KEY, B_PT);
        recv_frame(1'b0, got);
        checks++;
        if (got !== B_CT || bus.aes_key !== B_KEY) begin
            failures++;
            $display("FAIL reuse_no_key: ct=%h key=%h required %h %h", got, bus.aes_key, B_CT, B_KEY);
        end
    endtask

    task automatic test_timeout();
        int delta;
        bit saw_ov = 1'b0;
        do_reset();
        core_stuck = 1'b1;
        send_frame(1'b0, 1'b1, C1_KEY, C1_PT);
        for (int i = 0; i < 30 && bus.error !== 1'b1; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) saw_ov = 1'b1;
        end
        delta = (neg_cnt - 1) - trig_neg;
        checks++;
        if (bus.error !== 1'b1 || delta > 9 || delta < 1) begin
            failures++;
            $display("FAIL timeout_error: error=%b cycles=%0d required 1 within 9", bus.error, delta);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid) saw_ov = 1'b1;
        end
        checks++;
        if (saw_ov || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_idle: saw_out_valid=%b busy=%b in_ready=%b required 0 0 1",
                     saw_ov, bus.busy, bus.in_ready);
        end
        core_stuck = 1'b0;
        send_byte(8'h11);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_clear: error=%b busy=%b required 0 1", bus.error, bus.busy);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] got;
        int guard = 0;
        do_reset();
        bus.key_reuse = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(C1_KEY[127-8*i -: 8]);
        for (int i = 0; i < 5; i++) send_byte(C1_PT[127-8*i -: 8]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_values("areset_load");
        @(negedge clk);
        reset_n = 1'b1;
        send_frame(1'b1, 1'b1, B_KEY, B_PT);
        recv_frame(1'b0, got);
        checks++;
        if (got !== B_CT || bus.aes_key !== B_KEY) begin
            failures++;
            $display("FAIL areset_keyload: ct=%h key=%h required %h %h", got, bus.aes_key, B_CT, B_KEY);
        end
        send_frame(1'b0, 1'b1, C1_KEY, C1_PT);
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_send_entry: out_valid=%b required 1", bus.out_valid);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values("areset_send");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.key_reuse = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_c1();
        test_key_reuse();
        test_backpressure();
        test_reuse_no_key();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
